eth_avst_adapter_tx: RTL and testbench
======================================

# eth_avst_adapter_tx

Converts the MAC-lite TX MFB stream (one region, frames starting on any 8-byte block) into a 512-bit Ethernet Avalon-ST stream for the hard Ethernet IP, in which every packet starts at byte 0 of a word. It sits at the output of tx_mac_lite, in front of the E-tile/F-tile MAC. It is the transmit-side counterpart of the RX AVST-to-MFB adapter.

## Interface
- MFB_REGIONS, 1, MFB regions; only 1 is legal.
- MFB_REGION_SIZE, 8, blocks per region; only 8 is legal.
- MFB_BLOCK_SIZE, 8, items per block; only 8 is legal.
- MFB_ITEM_WIDTH, 8, bits per item; only 8 is legal.
- CLK  in  1  single clock.
- RESET  in  1  asynchronous, active-high reset.
- RX_MFB_DATA  in  512  frame data; byte k is at bits [8k+7:8k].
- RX_MFB_SOF_POS  in  3  block index of SOF (start offset S = 8*SOF_POS).
- RX_MFB_EOF_POS  in  6  byte index e of the last frame byte.
- RX_MFB_SOF  in  1  start of frame in this word.
- RX_MFB_EOF  in  1  end of frame in this word.
- RX_MFB_SRC_RDY  in  1  input word valid.
- RX_MFB_DST_RDY  out  1  adapter accepts the word.
- TX_AVST_DATA  out  512  packet data; byte 0 is at bits [7:0].
- TX_AVST_SOP  out  1  start of packet (always at byte 0).
- TX_AVST_EOP  out  1  end of packet.
- TX_AVST_EMPTY  out  6  count of unused top bytes in the EOP word.
- TX_AVST_VALID  out  1  output word valid.
- TX_AVST_READY  in  1  sink ready, readyLatency 0.

## Operation
- An input word transfers when SRC_RDY && DST_RDY. An output word transfers when VALID && READY.
- One 512-bit register REG holds the previously accepted word. Output byte i is taken from the 128-byte concatenation {cur, REG} at index W+i. REG occupies indices 0..63 and cur occupies 64..127.
- Each frame selects its mode from its own S, latched at SOF:
  - S=0: DIRECT mode, W=64. Output is cur, with no lag.
  - S>0: LAG mode, W=S. The SOF word is only stored in REG and produces no output. Each later word outputs REG[S..63] followed by cur[0..S-1].
- EOP handling in LAG mode:
  - If e<S: EOP is emitted in the same cycle, EMPTY = S-e-1.
  - If e>=S: the non-EOP word is emitted first. The state then goes to FLUSH, which emits REG[S..e] with EOP and EMPTY = 63-(e-S).
- DIRECT mode: EOP is always emitted in the same cycle, EMPTY = 63-e.
- A word carrying both SOF and EOF of a single LAG frame is stored, then goes to FLUSH. It emits one word with SOP=EOP=1.
- A word carrying EOF of frame A and SOF of frame B (SOF block > EOF block):
  - A finishes as described above.
  - REG keeps the word as B's head.
  - B is always in LAG mode.
- States:
  - IDLE: no frame open.
  - DIRECT / LAG: frame open.
  - FLUSH: one cycle, RX_MFB_DST_RDY=0. Exits to LAG if B was opened in that word, otherwise to IDLE.
- SOP is set on the first output word of each frame.
- An SOF while a frame is open, or an EOF while IDLE, is a protocol violation. Behaviour is undefined and is asserted in simulation.

## Timing
- Reset values: TX_AVST_VALID, SOP, EOP = 0; EMPTY = 0; DATA = 0; state IDLE; REG = 0.
- RX_MFB_DST_RDY = (!TX_AVST_VALID || TX_AVST_READY) && state != FLUSH && !RESET. It is combinational from READY.
- The output register loads only when !VALID || READY. It holds all fields stable while VALID && !READY.
- Latency:
  - DIRECT: input accepted at cycle t gives output valid at t+1.
  - LAG: the first output is valid the cycle after the second frame word is accepted.
  - FLUSH adds one cycle.
- Throughput: one word per cycle, except one bubble per LAG frame with e>=S.
- Reset mid-frame discards REG and the open frame; no EOP is emitted.

## Test plan
- 64 B frame, SOF_POS=0, EOF_POS=63 -> one word at t+1, SOP=EOP=1, EMPTY=0, DATA equals input.
- 100 B frame, SOF_POS=2, EOF_POS=51 in the 2nd word -> word 1 holds bytes 0..63 with SOP. FLUSH word holds 36 B with EOP, EMPTY=28. DST_RDY is low exactly 1 cycle.
- LAG frame, S=8, last word e=5 -> EOP in the same cycle as that word, EMPTY=2, no FLUSH.
- Frame A (DIRECT) EOF_POS=23 and frame B SOF_POS=4 in one word -> A EOP with EMPTY=40. B starts with SOP and B byte 0 = input byte 32.
- TX_AVST_READY low for 5 cycles mid-frame -> outputs frozen, DST_RDY low; the stream resumes with no loss or duplication.
- RESET pulse mid LAG frame -> VALID=0 immediately, state IDLE. A following aligned 64 B frame is output correctly.

Source files
------------

// File: rtl/eth_avst_adapter_tx.sv
// rtl/eth_avst_adapter_tx.sv - MFB (SOF on any block) to byte-0-aligned 512-bit Avalon-ST TX adapter
module eth_avst_adapter_tx #(
  parameter int MFB_REGIONS     = 1,
  parameter int MFB_REGION_SIZE = 8,
  parameter int MFB_BLOCK_SIZE  = 8,
  parameter int MFB_ITEM_WIDTH  = 8
) (
  input  logic                                                                    clk,
  input  logic                                                                    rst,
  input  logic [MFB_REGIONS*MFB_REGION_SIZE*MFB_BLOCK_SIZE*MFB_ITEM_WIDTH-1:0]   rx_mfb_data,
  input  logic [2:0]                                                              rx_mfb_sof_pos,
  input  logic [5:0]                                                              rx_mfb_eof_pos,
  input  logic                                                                    rx_mfb_sof,
  input  logic                                                                    rx_mfb_eof,
  input  logic                                                                    rx_mfb_src_rdy,
  output logic                                                                    rx_mfb_dst_rdy,
  output logic [MFB_REGIONS*MFB_REGION_SIZE*MFB_BLOCK_SIZE*MFB_ITEM_WIDTH-1:0]   tx_avst_data,
  output logic                                                                    tx_avst_sop,
  output logic                                                                    tx_avst_eop,
  output logic [5:0]                                                              tx_avst_empty,
  output logic                                                                    tx_avst_valid,
  input  logic                                                                    tx_avst_ready
);
  localparam int DATA_W = MFB_REGIONS*MFB_REGION_SIZE*MFB_BLOCK_SIZE*MFB_ITEM_WIDTH;

  typedef enum logic [1:0] {IDLE, DIRECT, LAG, FLUSH} state_t;

  state_t state, state_nxt, after_q, after_nxt;
  logic [DATA_W-1:0] reg_q, upper, lag_data, data_nxt;
  logic [2*DATA_W-1:0] cat;
  logic [2:0] s_q, s_nxt, bs_q, bs_nxt;
  logic [5:0] e_q, e_nxt, s_bytes, empty_nxt;
  logic sop_pend, sop_pend_nxt, valid_nxt, sop_nxt, eop_nxt;
  logic load, acc;

  assign load           = !tx_avst_valid || tx_avst_ready;
  assign rx_mfb_dst_rdy = load && (state != FLUSH) && !rst;
  assign acc            = rx_mfb_src_rdy && rx_mfb_dst_rdy;
  assign s_bytes        = {s_q, 3'b000};

  // Window starts at byte S of REG; in FLUSH only REG bytes are meaningful.
  assign upper    = (state == FLUSH) ? '0 : rx_mfb_data;
  assign cat      = {upper, reg_q};
  assign lag_data = DATA_W'(cat >> {s_q, 6'b000000});

  always_comb begin
    state_nxt    = state;
    after_nxt    = after_q;
    s_nxt        = s_q;
    bs_nxt       = bs_q;
    e_nxt        = e_q;
    sop_pend_nxt = sop_pend;
    valid_nxt    = tx_avst_valid && !tx_avst_ready;
    data_nxt     = tx_avst_data;
    sop_nxt      = tx_avst_sop;
    eop_nxt      = tx_avst_eop;
    empty_nxt    = tx_avst_empty;
    case (state)
      IDLE: begin
        if (acc && rx_mfb_sof) begin
          if (rx_mfb_sof_pos == 3'd0) begin
            valid_nxt = 1'b1;
            data_nxt  = rx_mfb_data;
            sop_nxt   = 1'b1;
            eop_nxt   = rx_mfb_eof;
            empty_nxt = rx_mfb_eof ? 6'd63 - rx_mfb_eof_pos : 6'd0;
            state_nxt = rx_mfb_eof ? IDLE : DIRECT;
          end else begin
            s_nxt        = rx_mfb_sof_pos;
            sop_pend_nxt = 1'b1;
            e_nxt        = rx_mfb_eof_pos;
            after_nxt    = IDLE;
            state_nxt    = rx_mfb_eof ? FLUSH : LAG;
          end
        end
      end
      DIRECT: begin
        if (acc) begin
          valid_nxt = 1'b1;
          data_nxt  = rx_mfb_data;
          sop_nxt   = 1'b0;
          eop_nxt   = rx_mfb_eof;
          empty_nxt = rx_mfb_eof ? 6'd63 - rx_mfb_eof_pos : 6'd0;
          if (rx_mfb_eof) begin
            state_nxt    = rx_mfb_sof ? LAG : IDLE;
            s_nxt        = rx_mfb_sof_pos;
            sop_pend_nxt = rx_mfb_sof;
          end
        end
      end
      LAG: begin
        if (acc) begin
          valid_nxt    = 1'b1;
          data_nxt     = lag_data;
          sop_nxt      = sop_pend;
          sop_pend_nxt = 1'b0;
          eop_nxt      = 1'b0;
          empty_nxt    = 6'd0;
          if (rx_mfb_eof && (rx_mfb_eof_pos < s_bytes)) begin
            eop_nxt   = 1'b1;
            empty_nxt = s_bytes - rx_mfb_eof_pos - 6'd1;
            if (rx_mfb_sof) begin
              s_nxt        = rx_mfb_sof_pos;
              sop_pend_nxt = 1'b1;
            end else begin
              state_nxt = IDLE;
            end
          end else if (rx_mfb_eof) begin
            // Frame tail still sits in this word; a following frame's head stays in REG too.
            e_nxt     = rx_mfb_eof_pos;
            bs_nxt    = rx_mfb_sof_pos;
            after_nxt = rx_mfb_sof ? LAG : IDLE;
            state_nxt = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (load) begin
          valid_nxt    = 1'b1;
          data_nxt     = lag_data;
          sop_nxt      = sop_pend;
          eop_nxt      = 1'b1;
          empty_nxt    = 6'd63 - (e_q - s_bytes);
          state_nxt    = after_q;
          s_nxt        = bs_q;
          sop_pend_nxt = (after_q == LAG);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      after_q       <= IDLE;
      reg_q         <= '0;
      s_q           <= '0;
      bs_q          <= '0;
      e_q           <= '0;
      sop_pend      <= 1'b0;
      tx_avst_valid <= 1'b0;
      tx_avst_data  <= '0;
      tx_avst_sop   <= 1'b0;
      tx_avst_eop   <= 1'b0;
      tx_avst_empty <= '0;
    end else begin
      state         <= state_nxt;
      after_q       <= after_nxt;
      s_q           <= s_nxt;
      bs_q          <= bs_nxt;
      e_q           <= e_nxt;
      sop_pend      <= sop_pend_nxt;
      tx_avst_valid <= valid_nxt;
      tx_avst_data  <= data_nxt;
      tx_avst_sop   <= sop_nxt;
      tx_avst_eop   <= eop_nxt;
      tx_avst_empty <= empty_nxt;
      if (acc) reg_q <= rx_mfb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && acc) begin
      assert (!(rx_mfb_sof && !rx_mfb_eof && (state == DIRECT || state == LAG)));
      assert (!(rx_mfb_eof && !rx_mfb_sof && state == IDLE));
    end
  end
endmodule

// File: tb/tb_eth_avst_adapter_tx.sv
// tb/tb_eth_avst_adapter_tx.sv - table-driven bench for eth_avst_adapter_tx
module tb_eth_avst_adapter_tx;
  logic clk = 1'b0;
  logic rst;
  logic [511:0] rx_mfb_data;
  logic [2:0] rx_mfb_sof_pos;
  logic [5:0] rx_mfb_eof_pos;
  logic rx_mfb_sof, rx_mfb_eof, rx_mfb_src_rdy, rx_mfb_dst_rdy;
  logic [511:0] tx_avst_data;
  logic tx_avst_sop, tx_avst_eop, tx_avst_valid, tx_avst_ready;
  logic [5:0] tx_avst_empty;

  always #5 clk = ~clk;

  eth_avst_adapter_tx dut (
    .clk(clk), .rst(rst),
    .rx_mfb_data(rx_mfb_data), .rx_mfb_sof_pos(rx_mfb_sof_pos), .rx_mfb_eof_pos(rx_mfb_eof_pos),
    .rx_mfb_sof(rx_mfb_sof), .rx_mfb_eof(rx_mfb_eof), .rx_mfb_src_rdy(rx_mfb_src_rdy),
    .rx_mfb_dst_rdy(rx_mfb_dst_rdy),
    .tx_avst_data(tx_avst_data), .tx_avst_sop(tx_avst_sop), .tx_avst_eop(tx_avst_eop),
    .tx_avst_empty(tx_avst_empty), .tx_avst_valid(tx_avst_valid), .tx_avst_ready(tx_avst_ready)
  );

  typedef struct {
    logic       src_rdy, sof, eof;
    logic [2:0] sof_pos;
    logic [5:0] eof_pos;
    logic [7:0] in_base;
    logic       ready;
    logic       exp_dst, exp_valid, exp_sop, exp_eop;
    logic [5:0] exp_empty;
    logic [7:0] exp_base;
  } vec_t;

  vec_t vecs[$];
  int tests = 0;
  int fails = 0;

  function automatic vec_t mk(int src, int sof, int eof, int sp, int ep, int ib, int rdy,
                              int ed, int ev, int es, int ee, int em, int eb);
    vec_t r;
    r.src_rdy = 1'(src); r.sof = 1'(sof); r.eof = 1'(eof);
    r.sof_pos = 3'(sp); r.eof_pos = 6'(ep); r.in_base = 8'(ib); r.ready = 1'(rdy);
    r.exp_dst = 1'(ed); r.exp_valid = 1'(ev); r.exp_sop = 1'(es); r.exp_eop = 1'(ee);
    r.exp_empty = 6'(em); r.exp_base = 8'(eb);
    return r;
  endfunction

  // Word byte k = base + k, so consecutive words with bases 64 apart form one contiguous byte stream.
  function automatic logic [511:0] pattern(logic [7:0] base);
    logic [511:0] p;
    for (int k = 0; k < 64; k++) p[8*k +: 8] = base + 8'(k);
    return p;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_data(string name, logic [7:0] base, int nbytes);
    logic [511:0] exp, mask;
    exp  = pattern(base);
    mask = '0;
    for (int k = 0; k < nbytes; k++) mask[8*k +: 8] = 8'hff;
    tests++;
    if ((tx_avst_data & mask) !== (exp & mask)) begin
      fails++;
      $display("FAIL %s: got %h expected %h (low %0d bytes)", name, tx_avst_data & mask, exp & mask, nbytes);
    end
  endtask

  task automatic apply(int idx);
    vec_t v;
    v = vecs[idx];
    @(negedge clk);
    rx_mfb_src_rdy = v.src_rdy;
    rx_mfb_sof     = v.sof;
    rx_mfb_eof     = v.eof;
    rx_mfb_sof_pos = v.sof_pos;
    rx_mfb_eof_pos = v.eof_pos;
    rx_mfb_data    = pattern(v.in_base);
    tx_avst_ready  = v.ready;
    #1;
    check($sformatf("v%0d_dst_rdy", idx), 64'(rx_mfb_dst_rdy), 64'(v.exp_dst));
    @(posedge clk);
    #1;
    check($sformatf("v%0d_valid", idx), 64'(tx_avst_valid), 64'(v.exp_valid));
    if (v.exp_valid) begin
      check($sformatf("v%0d_sop", idx), 64'(tx_avst_sop), 64'(v.exp_sop));
      check($sformatf("v%0d_eop", idx), 64'(tx_avst_eop), 64'(v.exp_eop));
      check($sformatf("v%0d_empty", idx), 64'(tx_avst_empty), 64'(v.exp_empty));
      check_data($sformatf("v%0d_data", idx), v.exp_base, v.exp_eop ? 64 - int'(v.exp_empty) : 64);
    end
  endtask

  initial begin
    rst = 1'b1;
    rx_mfb_src_rdy = 1'b0; rx_mfb_sof = 1'b0; rx_mfb_eof = 1'b0;
    rx_mfb_sof_pos = '0; rx_mfb_eof_pos = '0; rx_mfb_data = '0;
    tx_avst_ready = 1'b1;

    //       src sof eof sp  ep  in    rdy dst val sop eop emp exp
    vecs.push_back(mk(1, 1, 1, 0, 63, 'h00, 1, 1, 1, 1, 1, 0,  'h00)); // 0: aligned 64 B
    vecs.push_back(mk(0, 0, 0, 0, 0,  'h00, 1, 1, 0, 0, 0, 0,  'h00)); // 1: idle
    vecs.push_back(mk(1, 1, 0, 2, 0,  'h40, 1, 1, 0, 0, 0, 0,  'h00)); // 2: 100 B, S=16 head
    vecs.push_back(mk(1, 0, 1, 0, 51, 'h80, 1, 1, 1, 1, 0, 0,  'h50)); // 3: e>=S
    vecs.push_back(mk(1, 1, 0, 1, 0,  'h00, 1, 0, 1, 0, 1, 28, 'h90)); // 4: FLUSH, not accepted
    vecs.push_back(mk(1, 1, 0, 1, 0,  'h00, 1, 1, 0, 0, 0, 0,  'h00)); // 5: S=8 head
    vecs.push_back(mk(1, 0, 0, 0, 0,  'h40, 1, 1, 1, 1, 0, 0,  'h08)); // 6
    vecs.push_back(mk(1, 0, 1, 0, 5,  'h80, 1, 1, 1, 0, 1, 2,  'h48)); // 7: e<S, no FLUSH
    vecs.push_back(mk(1, 1, 0, 0, 0,  'h00, 1, 1, 1, 1, 0, 0,  'h00)); // 8: frame A direct
    vecs.push_back(mk(1, 1, 1, 4, 23, 'h40, 1, 1, 1, 0, 1, 40, 'h40)); // 9: A ends, B SOF
    vecs.push_back(mk(1, 0, 0, 0, 0,  'h80, 1, 1, 1, 1, 0, 0,  'h60)); // 10: B first out
    vecs.push_back(mk(1, 0, 0, 0, 0,  'hC0, 1, 1, 1, 0, 0, 0,  'hA0)); // 11
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(1, 0, 0, 0, 0, 'h00, 0, 0, 1, 0, 0, 0, 'hA0)); // 12..16: stalled
    vecs.push_back(mk(1, 0, 0, 0, 0,  'h00, 1, 1, 1, 0, 0, 0,  'hE0)); // 17: resume
    vecs.push_back(mk(1, 1, 1, 0, 63, 'h33, 1, 1, 1, 1, 1, 0,  'h33)); // 18: after reset
    vecs.push_back(mk(0, 0, 0, 0, 0,  'h00, 1, 1, 0, 0, 0, 0,  'h00)); // 19
    vecs.push_back(mk(1, 1, 1, 3, 40, 'h10, 1, 1, 0, 0, 0, 0,  'h00)); // 20: single-word LAG
    vecs.push_back(mk(0, 0, 0, 0, 0,  'h00, 1, 0, 1, 1, 1, 47, 'h28)); // 21: FLUSH SOP+EOP
    vecs.push_back(mk(0, 0, 0, 0, 0,  'h00, 1, 1, 0, 0, 0, 0,  'h00)); // 22

    repeat (2) @(negedge clk);
    check("reset_valid", 64'(tx_avst_valid), 64'd0);
    check("reset_sop", 64'(tx_avst_sop), 64'd0);
    check("reset_eop", 64'(tx_avst_eop), 64'd0);
    check("reset_empty", 64'(tx_avst_empty), 64'd0);
    check("reset_data_zero", 64'(tx_avst_data == '0), 64'd1);
    check("reset_dst_rdy", 64'(rx_mfb_dst_rdy), 64'd0);
    rst = 1'b0;
    #1;
    check("post_reset_dst_rdy", 64'(rx_mfb_dst_rdy), 64'd1);

    for (int i = 0; i <= 17; i++) apply(i);

    @(negedge clk);
    check("pre_rst_valid", 64'(tx_avst_valid), 64'd1);
    rx_mfb_src_rdy = 1'b0;
    rst = 1'b1;
    #1;
    check("midframe_rst_valid", 64'(tx_avst_valid), 64'd0);
    check("midframe_rst_dst_rdy", 64'(rx_mfb_dst_rdy), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 18; i < vecs.size(); i++) apply(i);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
